// File: rtl/debugger_pkg.sv
// Shared debugger types: firmware-sequencer state encoding, config bus idle id and table entry layout.
package debugger_pkg;

    typedef enum logic [2:0] {IDLE, DRAIN, WRITE, SETTLE, DONE} fw_seq_state_t;

    localparam logic [7:0] CONFIG_NOP = 8'hFF;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
    } cfg_entry_t;

endpackage

// File: rtl/fw_table.sv
// Firmware table: FW_DEPTH x cfg_entry_t simple dual-port RAM, one write port, registered read port.
module fw_table
    import debugger_pkg::*;
#(
    parameter int unsigned FW_DEPTH = 16,
    localparam int unsigned AW = $clog2(FW_DEPTH)
) (
    input  logic       clk_i,
    input  logic       wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  cfg_entry_t wr_entry_i,
    input  logic [AW-1:0] rd_addr_i,
    output cfg_entry_t rd_entry_o
);

    cfg_entry_t mem_q [FW_DEPTH];
    cfg_entry_t rd_entry_q;

    // Contents are deliberately not reset; the host loads them before use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_entry_i;
        end
        rd_entry_q <= mem_q[rd_addr_i];
    end

    assign rd_entry_o = rd_entry_q;

endmodule

// File: rtl/fw_sequencer.sv
// Firmware sequencer: gates tracing, waits for pipeline drain, replays the table onto the config
// bus one entry per cycle, settles, then restores tracing.
module fw_sequencer #(
    parameter int unsigned   FW_DEPTH      = 16,
    parameter int unsigned   NUM_STAGES    = 5,
    parameter int unsigned   DRAIN_CYCLES  = 4,
    parameter int unsigned   SETTLE_CYCLES = 2,
    parameter logic [7:0]    CONFIG_NOP    = debugger_pkg::CONFIG_NOP,
    localparam int unsigned  AW            = $clog2(FW_DEPTH),
    localparam int unsigned  LW            = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fw_wr_en,
    input  logic [AW-1:0]         fw_wr_addr,
    input  logic [7:0]            fw_wr_id,
    input  logic [7:0]            fw_wr_data,
    input  logic [LW-1:0]         fw_length,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] pipe_valid,
    input  logic                  tracing_in,
    output logic                  tracing,
    output logic [7:0]            configId,
    output logic [7:0]            configData,
    output logic                  busy,
    output logic                  done,
    output logic                  fw_wr_err
);
    import debugger_pkg::*;

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    fw_seq_state_t   state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic            rd_issue;
    logic [AW-1:0]   rd_addr;
    logic            rd_vld_q;
    cfg_entry_t      rd_entry;
    cfg_entry_t      wr_entry;
    logic            tbl_we;

    logic            tracing_q;
    logic [7:0]      cfg_id_q;
    logic [7:0]      cfg_data_q;
    logic            busy_q;
    logic            done_q;
    logic            wr_err_q;

    assign tbl_we   = fw_wr_en & ~busy_q;
    assign wr_entry = '{id: fw_wr_id, data: fw_wr_data};

    fw_table #(
        .FW_DEPTH(FW_DEPTH)
    ) u_table (
        .clk_i     (clk),
        .wr_en_i   (tbl_we),
        .wr_addr_i (fw_wr_addr),
        .wr_entry_i(wr_entry),
        .rd_addr_i (rd_addr),
        .rd_entry_o(rd_entry)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        drain_cnt_d  = drain_cnt_q;
        settle_cnt_d = settle_cnt_q;
        rd_issue     = 1'b0;
        rd_addr      = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = (fw_length > LW'(FW_DEPTH)) ? LW'(FW_DEPTH) : fw_length;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (|pipe_valid) begin
                    drain_cnt_d = '0;
                end else if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
                    drain_cnt_d  = '0;
                    settle_cnt_d = '0;
                    // Entry 0 is read on the last drain cycle so it reaches the bus registers
                    // one cycle later, hiding the table's read latency.
                    if (len_q != '0) begin
                        rd_issue = 1'b1;
                        addr_d   = LW'(1);
                        state_d  = WRITE;
                    end else begin
                        state_d = SETTLE;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            WRITE: begin
                if (addr_q < len_q) begin
                    rd_issue = 1'b1;
                    rd_addr  = addr_q[AW-1:0];
                    addr_d   = addr_q + LW'(1);
                end else if (!rd_vld_q) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_cnt_d = '0;
                    state_d      = DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            addr_q       <= '0;
            drain_cnt_q  <= '0;
            settle_cnt_q <= '0;
            rd_vld_q     <= 1'b0;
            tracing_q    <= 1'b0;
            cfg_id_q     <= CONFIG_NOP;
            cfg_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            drain_cnt_q  <= drain_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            rd_vld_q     <= rd_issue;
            tracing_q    <= (state_d == IDLE) ? tracing_in : 1'b0;
            cfg_id_q     <= rd_vld_q ? rd_entry.id : CONFIG_NOP;
            cfg_data_q   <= rd_vld_q ? rd_entry.data : 8'h00;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            wr_err_q     <= fw_wr_en & busy_q;
        end
    end

    assign tracing    = tracing_q;
    assign configId   = cfg_id_q;
    assign configData = cfg_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fw_wr_err  = wr_err_q;

endmodule

// File: tb/tb_fw_sequencer.sv
// Scoreboard bench for fw_sequencer: randomized sequences checked against a table/timing model.
module tb_fw_sequencer;

    localparam int FW_DEPTH      = 16;
    localparam int NUM_STAGES    = 5;
    localparam int DRAIN_CYCLES  = 4;
    localparam int SETTLE_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       fw_wr_en;
    logic [3:0] fw_wr_addr;
    logic [7:0] fw_wr_id;
    logic [7:0] fw_wr_data;
    logic [4:0] fw_length;
    logic       start;
    logic [4:0] pipe_valid;
    logic       tracing_in;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       done;
    logic       fw_wr_err;

    fw_sequencer #(
        .FW_DEPTH     (FW_DEPTH),
        .NUM_STAGES   (NUM_STAGES),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CONFIG_NOP   (8'hFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fw_wr_en  (fw_wr_en),
        .fw_wr_addr(fw_wr_addr),
        .fw_wr_id  (fw_wr_id),
        .fw_wr_data(fw_wr_data),
        .fw_length (fw_length),
        .start     (start),
        .pipe_valid(pipe_valid),
        .tracing_in(tracing_in),
        .tracing   (tracing),
        .configId  (configId),
        .configData(configData),
        .busy      (busy),
        .done      (done),
        .fw_wr_err (fw_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_id   [FW_DEPTH];
    logic [7:0] m_data [FW_DEPTH];
    int         nvec     = 0;
    int         nerr     = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    bit         mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every non-idle bus cycle must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) done_cnt++;
            if (configId !== 8'hFF) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_write: got id %0h data %0h at cycle %0d, required none",
                             configId, configData, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_id", configId, e.id);
                    chk("write_data", configData, e.data);
                    chk("write_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input int a, input logic [7:0] id, input logic [7:0] data);
        fw_wr_en   = 1'b1;
        fw_wr_addr = 4'(a);
        fw_wr_id   = id;
        fw_wr_data = data;
        m_id[a]    = id;
        m_data[a]  = data;
        step();
        fw_wr_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        start      = 1'b0;
        fw_wr_en   = 1'b0;
        pipe_valid = '0;
        repeat (n) step();
    endtask

    // One full sequence. vcyc: cycles after start with some stage valid (vpat, or random if 0).
    // poke: write and restart while busy, plus a start on the DONE cycle.
    task automatic run_seq(input int len, input int vcyc, input logic [4:0] vpat,
                           input bit poke, input bit wr_at_start);
        int   eff, c, dn, base, gate_bad, d0;
        logic tr_dn;
        eff = (len > FW_DEPTH) ? FW_DEPTH : len;
        c   = vcyc + DRAIN_CYCLES;
        dn  = (eff > 0) ? c + eff + SETTLE_CYCLES + 2 : c + SETTLE_CYCLES + 1;
        if (wr_at_start) begin
            int a;
            a          = $urandom_range(0, FW_DEPTH - 1);
            fw_wr_en   = 1'b1;
            fw_wr_addr = 4'(a);
            fw_wr_id   = 8'($urandom_range(0, 254));
            fw_wr_data = 8'($urandom);
            m_id[a]    = fw_wr_id;
            m_data[a]  = fw_wr_data;
        end
        base = cyc;
        for (int i = 0; i < eff; i++) exp_q.push_back('{m_id[i], m_data[i], base + c + 2 + i});
        d0         = done_cnt;
        gate_bad   = 0;
        tr_dn      = 1'b0;
        fw_length  = 5'(len);
        start      = 1'b1;
        pipe_valid = 5'($urandom);
        tracing_in = 1'($urandom);
        for (int k = 1; k <= dn + 1; k++) begin
            step();
            start    = 1'b0;
            fw_wr_en = 1'b0;
            if (k == 1) begin
                chk("busy_after_start", busy, 1);
                chk("no_err_idle_write", fw_wr_err, 0);
            end
            if (k <= dn && tracing !== 1'b0) gate_bad++;
            if (k == dn) chk("done_pulse", done, 1);
            if (k == dn + 1) begin
                chk("busy_fall", busy, 0);
                chk("done_single_cycle", done, 0);
                chk("tracing_restore", tracing, tr_dn);
            end
            if (poke && k == c + 3) chk("wr_err_pulse", fw_wr_err, 1);
            if (k <= vcyc) pipe_valid = (vpat != 0) ? vpat : 5'($urandom_range(1, 31));
            else if (k <= c) pipe_valid = '0;
            else pipe_valid = 5'($urandom);
            tracing_in = 1'($urandom);
            if (k == dn) tr_dn = tracing_in;
            if (poke && k == c + 2) begin
                fw_wr_en   = 1'b1;
                fw_wr_addr = 4'($urandom_range(0, FW_DEPTH - 1));
                fw_wr_id   = 8'($urandom_range(0, 254));
                fw_wr_data = 8'($urandom);
            end
            if (poke && (k == c + 3 || k == dn)) begin
                start     = 1'b1;
                fw_length = 5'($urandom_range(1, 16));
            end
        end
        chk("tracing_gated", gate_bad, 0);
        idle_cycles(3);
        chk("one_done_per_seq", done_cnt - d0, 1);
        chk("writes_all_seen", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        fw_wr_en   = 1'b0;
        fw_wr_addr = '0;
        fw_wr_id   = '0;
        fw_wr_data = '0;
        fw_length  = '0;
        start      = 1'b0;
        pipe_valid = '0;
        tracing_in = 1'b1;
        repeat (3) step();
        chk("reset_tracing", tracing, 0);
        chk("reset_configId", configId, 8'hFF);
        chk("reset_configData", configData, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_wr_err", fw_wr_err, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        step();
        chk("idle_tracing_follow", tracing, 1);

        for (int i = 0; i < FW_DEPTH; i++)
            tbl_write(i, 8'($urandom_range(0, 254)), 8'($urandom));

        // Directed: three-entry replay on an idle pipeline.
        tbl_write(0, 8'h01, 8'h10);
        tbl_write(1, 8'h02, 8'h20);
        tbl_write(2, 8'h04, 8'h03);
        run_seq(3, 0, 5'b0, 1'b0, 1'b0);
        // Stage 2 busy for 10 cycles holds off the drain.
        run_seq(3, 10, 5'b00100, 1'b0, 1'b0);
        // Empty table replay.
        run_seq(0, 0, 5'b0, 1'b0, 1'b0);
        // Write and restart while busy; next replay must see the original table.
        run_seq(5, 0, 5'b0, 1'b1, 1'b0);
        run_seq(5, 0, 5'b0, 1'b0, 1'b0);
        // Full-depth and saturated lengths.
        run_seq(16, 1, 5'b0, 1'b0, 1'b0);
        run_seq(20, 0, 5'b0, 1'b0, 1'b1);

        // Reset after two of five entries reach the bus.
        for (int i = 0; i < 5; i++) tbl_write(i, 8'($urandom_range(0, 254)), 8'($urandom));
        begin
            int base;
            base = cyc;
            exp_q.push_back('{m_id[0], m_data[0], base + DRAIN_CYCLES + 2});
            exp_q.push_back('{m_id[1], m_data[1], base + DRAIN_CYCLES + 3});
            fw_length  = 5'd5;
            start      = 1'b1;
            pipe_valid = '0;
            tracing_in = 1'b1;
            for (int k = 1; k <= DRAIN_CYCLES + 3; k++) begin
                step();
                start = 1'b0;
            end
            reset = 1'b1;
            step();
            chk("rst_mid_configId", configId, 8'hFF);
            chk("rst_mid_tracing", tracing, 0);
            chk("rst_mid_busy", busy, 0);
            reset = 1'b0;
            idle_cycles(12);
            chk("rst_mid_no_more_writes", exp_q.size(), 0);
        end

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 1) == 1)
                tbl_write($urandom_range(0, FW_DEPTH - 1), 8'($urandom_range(0, 254)), 8'($urandom));
            run_seq($urandom_range(0, 20), $urandom_range(0, 6), 5'b0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
